// File: rtl/fp_div_writeback.sv
// rtl/fp_div_writeback.sv - FP divider result capture with special-case resolution and 2-entry output FIFO
// Optional feature macro: FDIV_SPECIAL_CASE_EN (IEEE special-case resolution and sign correction)
module fp_div_writeback #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [XLEN-1:0]  in_quot,
   input  logic             in_zdiv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [3:0]       out_flags,
   output logic [3:0]       sticky_flags,
   input  logic             flag_clr,
   output logic [CNT_W-1:0] op_count
);
   logic            w_push;
   logic            w_pop;
   logic [XLEN-1:0] w_res;
   logic [3:0]      w_flags;
   logic [7:0]      w_ea;

   logic [XLEN-1:0]  r_data [2];
   logic [3:0]       r_flg  [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;
   logic [3:0]       r_sticky;
   logic [CNT_W-1:0] r_op_count;

   assign w_ea = in_a[30:23];

`ifdef FDIV_SPECIAL_CASE_EN
   logic       w_sign;
   logic [7:0] w_eb;
   logic [7:0] w_eq;
   logic       w_nan_a;
   logic       w_nan_b;
   logic       w_inf_a;
   logic       w_inf_b;
   logic       w_unused;

   assign w_sign   = in_a[31] ^ in_b[31];
   assign w_eb     = in_b[30:23];
   assign w_eq     = in_quot[30:23];
   assign w_nan_a  = (w_ea == 8'hFF) && (in_a[22:0] != 23'h0);
   assign w_nan_b  = (w_eb == 8'hFF) && (in_b[22:0] != 23'h0);
   assign w_inf_a  = (w_ea == 8'hFF) && (in_a[22:0] == 23'h0);
   assign w_inf_b  = (w_eb == 8'hFF) && (in_b[22:0] == 23'h0);
   // The divider's own zero flag and quotient sign are superseded by operand classification
   assign w_unused = in_zdiv ^ in_quot[31];

   // First-match special-case resolution; denormal operands count as zero
   always_comb begin
      w_res   = {w_sign, in_quot[30:0]};
      w_flags = 4'b0000;
      if (w_nan_a || w_nan_b) begin
         w_res   = 32'h7FC0_0000;
         w_flags = 4'b1000;
      end else if ((w_inf_a && w_inf_b) || (w_ea == 8'h00 && w_eb == 8'h00)) begin
         w_res   = 32'h7FC0_0000;
         w_flags = 4'b1000;
      end else if (w_inf_a) begin
         w_res   = {w_sign, 8'hFF, 23'h0};
      end else if (w_eb == 8'h00) begin
         w_res   = {w_sign, 8'hFF, 23'h0};
         w_flags = 4'b0100;
      end else if (w_inf_b || w_ea == 8'h00) begin
         w_res   = {w_sign, 31'h0};
      end else if (w_eq == 8'hFF) begin
         w_res   = {w_sign, 8'hFF, 23'h0};
         w_flags = 4'b0010;
      end else if (w_eq == 8'h00) begin
         w_res   = {w_sign, 31'h0};
         w_flags = 4'b0001;
      end
   end
`else
   logic w_unused;

   // Minimal build only looks at the dividend exponent and the divider's zero flag
   assign w_unused = ^{in_a[31], in_a[22:0], in_b};

   // Zero dividend or divide-by-zero collapses to +0; DZ passed through
   always_comb begin
      w_res   = (w_ea == 8'h00 || in_zdiv) ? '0 : in_quot;
      w_flags = {1'b0, in_zdiv, 2'b00};
   end
`endif

   assign in_ready     = (r_count != 2'd2);
   assign out_valid    = (r_count != 2'd0);
   assign w_push       = in_valid & in_ready;
   assign w_pop        = out_valid & out_ready;
   assign out_result   = r_data[r_rptr];
   assign out_flags    = r_flg[r_rptr];
   assign sticky_flags = r_sticky;
   assign op_count     = r_op_count;

   // FIFO storage, pointers and occupancy; simultaneous push/pop at count 1 replaces the head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_flg[0]  <= 4'b0000;
         r_flg[1]  <= 4'b0000;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_data[r_wptr] <= w_res;
            r_flg[r_wptr]  <= w_flags;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 2'd1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

   // Sticky exception flags; a same-cycle flag set wins over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 4'b0000;
      end else if (w_push) begin
         r_sticky <= (flag_clr ? 4'b0000 : r_sticky) | w_flags;
      end else if (flag_clr) begin
         r_sticky <= 4'b0000;
      end
   end

   // Accepted-operation counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_push) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_fp_div_writeback.sv
// tb/tb_fp_div_writeback.sv - randomized self-checking bench for fp_div_writeback against a queue reference model
module tb_fp_div_writeback;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] in_quot;
   logic        in_zdiv;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;
   logic [3:0]  sticky_flags;
   logic        flag_clr;
   logic [3:0]  op_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [35:0] mq[$];
   logic [3:0]  m_sticky;
   logic [3:0]  m_cnt;

   fp_div_writeback #(.XLEN(32), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_quot(in_quot), .in_zdiv(in_zdiv),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .sticky_flags(sticky_flags), .flag_clr(flag_clr), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected {result, flags} for one operation, from the operand classes
   function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] q, input logic z);
`ifdef FDIV_SPECIAL_CASE_EN
      logic s;
      bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
      s      = a[31] ^ b[31];
      nan_a  = (a[30:23] == 255) && (a[22:0] != 0);
      nan_b  = (b[30:23] == 255) && (b[22:0] != 0);
      inf_a  = (a[30:23] == 255) && (a[22:0] == 0);
      inf_b  = (b[30:23] == 255) && (b[22:0] == 0);
      zero_a = (a[30:23] == 0);
      zero_b = (b[30:23] == 0);
      if (nan_a || nan_b)                         return {32'h7FC00000, 4'b1000};
      if ((inf_a && inf_b) || (zero_a && zero_b)) return {32'h7FC00000, 4'b1000};
      if (inf_a)                                  return {s, 31'h7F800000, 4'b0000};
      if (zero_b)                                 return {s, 31'h7F800000, 4'b0100};
      if (inf_b || zero_a)                        return {s, 31'h0, 4'b0000};
      if (q[30:23] == 255)                        return {s, 31'h7F800000, 4'b0010};
      if (q[30:23] == 0)                          return {s, 31'h0, 4'b0001};
      return {s, q[30:0], 4'b0000};
`else
      logic [31:0] r;
      r = (a[30:23] == 0 || z) ? 32'h0 : q;
      return {r, 1'b0, z, 2'b00};
`endif
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [7:0]  e;
      logic [22:0] m;
      case ($urandom % 5)
         0:       e = 8'h00;
         1:       e = 8'hFF;
         default: e = 8'($urandom);
      endcase
      m = ($urandom % 3 == 0) ? 23'h0 : 23'($urandom);
      return {1'($urandom), e, m};
   endfunction

   // Check the visible state against the model, apply one cycle of stimulus, advance the model
   task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic z, input logic ordy, input logic clr);
      bit          push, pop;
      logic [35:0] e;
      check("in_ready", in_ready, mq.size() != 2);
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         check("out_result", out_result, mq[0][35:4]);
         check("out_flags", out_flags, mq[0][3:0]);
      end
      check("sticky_flags", sticky_flags, m_sticky);
      check("op_count", op_count, m_cnt);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_quot   = q;
      in_zdiv   = z;
      out_ready = ordy;
      flag_clr  = clr;
      push = v && (mq.size() != 2);
      pop  = ordy && (mq.size() != 0);
      e    = ref_op(a, b, q, z);
      @(posedge clk);
      #1;
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(e);
         m_sticky = (clr ? 4'b0000 : m_sticky) | e[3:0];
         m_cnt    = m_cnt + 4'd1;
      end else if (clr) begin
         m_sticky = 4'b0000;
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
   endtask

   task automatic model_reset();
      mq.delete();
      m_sticky = 4'b0000;
      m_cnt    = 4'd0;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flag_clr  = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_a = 0; in_b = 0; in_quot = 0; in_zdiv = 0;
      do_reset();

      // reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sticky", sticky_flags, 0);
      check("rst_op_count", op_count, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_flags", out_flags, 0);

      // normal op, one-cycle latency
      cycle(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b1, 1'b0);
      check("norm_valid", out_valid, 1);
      check("norm_result", out_result, 32'h40400000);
      check("norm_flags", out_flags, 4'b0000);
      idle(1'b1);

      // divide by zero; sticky DZ persists until cleared
      cycle(1'b1, 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b1, 1'b0);
      check("dz_flags", out_flags, 4'b0100);
`ifdef FDIV_SPECIAL_CASE_EN
      check("dz_result", out_result, 32'hFF800000);
`else
      check("dz_result", out_result, 32'h00000000);
`endif
      idle(1'b1);
      idle(1'b1);
      check("dz_sticky_hold", sticky_flags[2], 1);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      check("dz_sticky_clr", sticky_flags, 0);

      // backpressure: three offers, two accepted, then drain in order
      do_reset();
      cycle(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h40000000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h40400000, 32'h3F800000, 32'h40400000, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", in_ready, 0);
      check("bp_op_count", op_count, 2);
      check("bp_head", out_result, 32'h3F800000);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("bp_ready_back", in_ready, 1);
      check("bp_second", out_result, 32'h40000000);
      idle(1'b1);
      check("bp_empty", out_valid, 0);

      // invalid operations and same-cycle set-over-clear
      cycle(1'b1, 32'h3F800000, 32'h7FC00001, 32'h12345678, 1'b0, 1'b1, 1'b0);
`ifdef FDIV_SPECIAL_CASE_EN
      check("nan_result", out_result, 32'h7FC00000);
      check("nan_flags", out_flags, 4'b1000);
`endif
      cycle(1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 32'h7F800001, 32'h3F800000, 32'h0, 1'b0, 1'b1, 1'b1);
`ifdef FDIV_SPECIAL_CASE_EN
      check("clr_vs_set", sticky_flags, 4'b1000);
`endif
      idle(1'b1);

      // zero over zero
      cycle(1'b1, 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b1, 1'b0);
`ifdef FDIV_SPECIAL_CASE_EN
      check("zz_result", out_result, 32'h7FC00000);
      check("zz_flags", out_flags, 4'b1000);
`else
      check("zz_result", out_result, 32'h00000000);
      check("zz_flags", out_flags, 4'b0100);
`endif
      idle(1'b1);

      // counter wrap at 16 pushes
      do_reset();
      for (int i = 0; i < 16; i++)
         cycle(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 1'b0);
      check("wrap_op_count", op_count, 0);
      idle(1'b1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         a = rnd_fp();
         b = rnd_fp();
         cycle(1'($urandom % 4 != 0), a, b, rnd_fp(),
               (b[30:23] == 0) ? 1'b1 : 1'($urandom % 8 == 0),
               1'($urandom % 3 != 0), 1'($urandom % 8 == 0));
      end

      // asynchronous reset with entries in flight
      cycle(1'b1, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h40C00000, 32'h00000000, 32'h40400000, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_out_valid", out_valid, 0);
      check("arst_result", out_result, 0);
      check("arst_flags", out_flags, 0);
      check("arst_sticky", sticky_flags, 0);
      check("arst_op_count", op_count, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(1'b1);
      idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
